data_cache_bank_array: RTL

DATA_CACHE_BANK_ARRAY -- requirements
Module: data_cache_bank_array

---
 rtl/data_cache_bank_array.sv | 135 +++++++++++++
 1 files changed

// File: rtl/data_cache_bank_array.sv
// Data cache bank: DEPTH x DATA_W data array with a per-entry valid vector.
// Single-port access (read or byte-masked write) with a one-cycle registered response,
// and a flush sweep that clears the valid bits one entry per cycle.
//
// Ports:
//   clk       - clock, rising-edge
//   rst_n     - asynchronous active-low reset
//   en_i      - access request
//   we_i      - 1 = write, 0 = read (qualified by en_i)
//   addr_i    - entry index
//   wstrb_i   - byte write enables
//   wdata_i   - write data
//   flush_i   - start a flush sweep (takes priority over a same-cycle access)
//   rdata_o   - registered access result
//   rvalid_o  - rdata_o/hit_o were updated by the previous cycle's access
//   hit_o     - valid bit of the accessed entry before any update
//   busy_o    - flush sweep in progress; accesses are dropped
module data_cache_bank_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                hit_o,
  output logic                busy_o
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              hit_q, hit_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic [DATA_W-1:0] cur_entry;
  logic [DATA_W-1:0] merged;

  // Flush in IDLE wins over a same-cycle access; nothing is accepted while sweeping.
  assign accept    = (state_q == StIdle) && en_i && !flush_i;
  assign cur_entry = mem_q[addr_i];

  always_comb begin
    merged = cur_entry;
    for (int unsigned b = 0; b < DATA_W / 8; b++) begin
      if (wstrb_i[b]) begin
        merged[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    rvalid_d = accept;

    case (state_q)
      StIdle: begin
        if (flush_i) begin
          state_d = StFlush;
          idx_d   = '0;
        end
      end
      StFlush: begin
        valid_d[idx_q] = 1'b0;
        idx_d          = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      // hit reflects the valid bit before this access updates it.
      hit_d = valid_q[addr_i];
      if (we_i) begin
        valid_d[addr_i] = 1'b1;
        rdata_d         = merged;
      end else begin
        rdata_d         = cur_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      valid_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      hit_q    <= hit_d;
    end
  end

  // Data array is not reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (accept && we_i) begin
      mem_q[addr_i] <= merged;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign hit_o    = hit_q;
  assign busy_o   = (state_q == StFlush);

endmodule
